// File: rtl/csa_seq_pkg.sv
// =============================================================================
// csa_seq_pkg : shared types and constants for the nibble-serial adder sequencer
// Rev 1.0
// =============================================================================
`default_nettype none

package csa_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Nibble counter width; never below one bit so NIBBLES=1 still has a counter.
    function automatic int calc_cnt_w(input int width);
        int nibbles;
        nibbles = width / NIBBLE_W;
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/csa_seq_ctrl_if.sv
// =============================================================================
// csa_seq_ctrl_if : operand/result handshake bundle (CSA_SEQ_SUB_EN adds sub)
// Rev 1.0
// =============================================================================
`default_nettype none

interface csa_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CSA_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef CSA_SEQ_SUB_EN
        output sub,
`endif
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CSA_SEQ_SUB_EN
        input  sub,
`endif
        output in_ready, out_valid, sum, cout, busy
    );

endinterface

`default_nettype wire

// File: rtl/csa_seq_ctrl_csa4_slice.sv
// =============================================================================
// csa4_slice : combinational 4-bit carry-select adder slice
// Rev 1.0
// =============================================================================
`default_nettype none

module csa4_slice
    import csa_seq_pkg::*;
(
    input  wire logic [NIBBLE_W-1:0] a4,
    input  wire logic [NIBBLE_W-1:0] b4,
    input  wire logic                ci,
    output logic      [NIBBLE_W-1:0] s4,
    output logic                     co
);

    logic [NIBBLE_W-1:0] s0;
    logic [NIBBLE_W-1:0] s1;
    logic [NIBBLE_W:0]   c0;
    logic [NIBBLE_W:0]   c1;

    // Both carry-in hypotheses ripple in parallel; ci only drives the final mux.
    always_comb begin
        s0    = '0;
        s1    = '0;
        c0    = '0;
        c1    = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s0[i]   = a4[i] ^ b4[i] ^ c0[i];
            c0[i+1] = (a4[i] & b4[i]) | (c0[i] & (a4[i] ^ b4[i]));
            s1[i]   = a4[i] ^ b4[i] ^ c1[i];
            c1[i+1] = (a4[i] & b4[i]) | (c1[i] & (a4[i] ^ b4[i]));
        end
        s4 = ci ? s1 : s0;
        co = ci ? c1[NIBBLE_W] : c0[NIBBLE_W];
    end

endmodule

`default_nettype wire

// File: rtl/csa_seq_ctrl.sv
// =============================================================================
// csa_seq_ctrl : WIDTH-bit adder reusing one 4-bit slice, LS nibble first
//                (CSA_SEQ_SUB_EN enables a - b via the sub input)
// Rev 1.0
// =============================================================================
`default_nettype none

module csa_seq_ctrl
    import csa_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    csa_seq_ctrl_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = calc_cnt_w(WIDTH);

    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("csa_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic                carry_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    sum_q;
    logic                cout_q;
`ifdef CSA_SEQ_SUB_EN
    logic                sub_q;
`endif

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;
    logic                carry_init;

    generate
        for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
            assign a_nib[i] = a_q[i*NIBBLE_W +: NIBBLE_W];
            assign b_nib[i] = b_q[i*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign slice_a = a_nib[cnt];
`ifdef CSA_SEQ_SUB_EN
    // Subtraction is a + ~b + 1: invert B per nibble and force the initial carry.
    assign slice_b    = sub_q ? ~b_nib[cnt] : b_nib[cnt];
    assign carry_init = bus.sub ? 1'b1 : bus.cin;
`else
    assign slice_b    = b_nib[cnt];
    assign carry_init = bus.cin;
`endif

    csa4_slice u_slice (
        .a4 (slice_a),
        .b4 (slice_b),
        .ci (carry_q),
        .s4 (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cout_q  <= 1'b0;
`ifdef CSA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= carry_init;
                        cnt     <= '0;
`ifdef CSA_SEQ_SUB_EN
                        sub_q   <= bus.sub;
`endif
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    carry_q <= slice_co;
                    if (cnt == LAST_NIB) begin
                        cout_q <= slice_co;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Only the nibble addressed by cnt is written; the rest of the sum holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (state == S_RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (cnt == CNT_W'(i)) begin
                    sum_q[i*NIBBLE_W +: NIBBLE_W] <= slice_s;
                end
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_csa_seq_ctrl.sv
// =============================================================================
// tb_csa_seq_ctrl : scoreboard bench for csa_seq_ctrl (CSA_SEQ_SUB_EN adds sub tests)
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_csa_seq_ctrl;

    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    csa_seq_ctrl_if #(.WIDTH(W)) bus ();

    csa_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q [$];

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the accept edge, queue the expected result.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        int n;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
`ifdef CSA_SEQ_SUB_EN
        bus.sub      = sub;
`endif
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        bus.in_valid = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        exp_q.push_back(model(a, b, cin, sub));
`else
        exp_q.push_back(model(a, b, cin, 1'b0));
`endif
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop_exp(output logic [W:0] e);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags: got in_ready/out_valid/busy=%b want 100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end
        checks++;
        if ({bus.cout, bus.sum} !== '0) begin
            errors++;
            $display("FAIL reset_result: got %h want 0", {bus.cout, bus.sum});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_latency();
        int lat;
        logic [W:0] e;
        drive_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
        end
        pop_exp(e);
        checks++;
        if ({bus.cout, bus.sum} !== e || e !== 17'h05555) begin
            errors++;
            $display("FAIL basic_sum: got %h want %h", {bus.cout, bus.sum}, e);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic_release: got in_ready/out_valid/busy=%b want 100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end
    endtask

    task automatic test_arith_table();
        logic [W-1:0] ta [4] = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0F0F};
        logic [W-1:0] tb [4] = '{16'h0001, 16'h0000, 16'h8000, 16'hF0F1};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] a, b;
        logic         c;
        logic [W:0]   e;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                a = ta[i]; b = tb[i]; c = tc[i];
            end else begin
                a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            end
            drive_op(a, b, c, 1'b0);
            wait_out(lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d want %0d", i, lat, LAT);
            end
            pop_exp(e);
            checks++;
            if ({bus.cout, bus.sum} !== e) begin
                errors++;
                $display("FAIL arith_sum[%0d] a=%h b=%h cin=%b: got %h want %h",
                         i, a, b, c, {bus.cout, bus.sum}, e);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
    endtask

    // Continuous valid/ready: accepts every NIBBLES+2 cycles.
    task automatic test_back_to_back();
        logic [W:0] e;
        bus.out_ready = 1'b1;
        bus.a = 16'h00F0; bus.b = 16'h0F10; bus.cin = 1'b1;
        bus.in_valid = 1'b1;
        for (int t = 0; t <= 3 * (LAT + 2); t++) begin
            checks++;
            if (bus.in_ready !== (t % (LAT + 2) == 0) ||
                bus.out_valid !== (t % (LAT + 2) == LAT + 1)) begin
                errors++;
                $display("FAIL b2b_timing[t=%0d]: got in_ready=%b out_valid=%b", t,
                         bus.in_ready, bus.out_valid);
            end
            if (bus.out_valid) begin
                pop_exp(e);
                checks++;
                if ({bus.cout, bus.sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_sum[t=%0d]: got %h want %h", t, {bus.cout, bus.sum}, e);
                end
            end
            if (t == 3 * (LAT + 2)) break;
            if (bus.in_ready) exp_q.push_back(model(bus.a, bus.b, bus.cin, 1'b0));
            tick();
            bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d pending want 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] e;
        int lat;
        drive_op(16'h0ABC, 16'h0111, 1'b1, 1'b0);
        wait_out(lat);
        pop_exp(e);
        bus.a = 16'h7FFF; bus.b = 16'h0001; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b101 || {bus.cout, bus.sum} !== e) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got ov/ir/busy=%b res=%h want 101 res=%h", i,
                         {bus.out_valid, bus.in_ready, bus.busy}, {bus.cout, bus.sum}, e);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: got in_ready/out_valid=%b want 10",
                     {bus.in_ready, bus.out_valid});
        end
        exp_q.push_back(model(16'h7FFF, 16'h0001, 1'b0, 1'b0));
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_queued_accept: got busy=%b want 1", bus.busy);
        end
        wait_out(lat);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL bp_latency: got %0d want %0d", lat, LAT);
        end
        pop_exp(e);
        checks++;
        if ({bus.cout, bus.sum} !== e) begin
            errors++;
            $display("FAIL bp_sum: got %h want %h", {bus.cout, bus.sum}, e);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        drive_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.sum} !== {3'b100, 17'h0}) begin
            errors++;
            $display("FAIL midrun_reset: got ir/ov/busy=%b res=%h want 100 res=0",
                     {bus.in_ready, bus.out_valid, bus.busy}, {bus.cout, bus.sum});
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_no_output: got %0d out_valid cycles want 0", seen);
        end
    endtask

`ifdef CSA_SEQ_SUB_EN
    task automatic test_sub();
        logic [W-1:0] sa [2] = '{16'h0005, 16'h0007};
        logic [W-1:0] sb [2] = '{16'h0007, 16'h0005};
        logic [W:0]   want [2] = '{17'h0FFFE, 17'h10002};
        logic [W:0]   e;
        int lat;
        for (int i = 0; i < 2; i++) begin
            drive_op(sa[i], sb[i], 1'b0, 1'b1);
            wait_out(lat);
            pop_exp(e);
            checks++;
            if ({bus.cout, bus.sum} !== e || e !== want[i]) begin
                errors++;
                $display("FAIL sub[%0d]: got %h want %h", i, {bus.cout, bus.sum}, want[i]);
            end
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        bus.sub = 1'b0;
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef CSA_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        test_reset();
        test_basic_latency();
        test_arith_table();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
`ifdef CSA_SEQ_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
